// File: rtl/eq_pkg.sv
// Shared types and defaults for the FIR tap read sequencer and its delay-line RAM.
package eq_pkg;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        LOAD  = 2'd2,
        RUN   = 2'd3
    } state_e;

    typedef logic signed [DATA_W_DEF-1:0] sample_t;

endpackage

// File: rtl/tap_read_sequencer_ram.sv
// Circular delay-line storage: one write port, one registered read port.
module tap_delay_ram #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // rdata holds its value when no read is issued; the sequencer relies on it as a prefetch slot
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[waddr] <= wdata;
        end
        if (en && re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/tap_read_sequencer.sv
// FIR delay-line reader: stores samples and streams newest-to-oldest taps to the MAC.
// Optional one-entry pending-sample queue enabled by TAP_SEQ_SAMPLE_QUEUE_EN.
module tap_read_sequencer
    import eq_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_enable,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    output logic              tap_valid,
    input  logic              tap_ready,
    output logic [DATA_W-1:0] tap_data,
    output logic [ADDR_W-1:0] coef_addr,
    output logic              tap_last,
    output logic              busy,
    output logic              overrun
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] rd_k_q, rd_k_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              tap_valid_q, tap_valid_d;
    logic [DATA_W-1:0] tap_data_q, tap_data_d;
    logic [ADDR_W-1:0] coef_addr_q, coef_addr_d;
    logic              tap_last_q, tap_last_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
`ifdef TAP_SEQ_SAMPLE_QUEUE_EN
    logic              pend_valid_q, pend_valid_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
`endif

    logic              ram_en_c;
    logic              ram_we_c;
    logic [ADDR_W-1:0] ram_waddr_c;
    logic [DATA_W-1:0] ram_wdata_c;
    logic              ram_re_c;
    logic [ADDR_W-1:0] ram_raddr_c;
    logic [DATA_W-1:0] ram_rdata;
    logic              start_c;
    logic [DATA_W-1:0] start_data_c;
    logic [ADDR_W-1:0] coef_next_c;

    assign ram_en_c = clk_enable && !rst;

    tap_delay_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en_c),
        .we    (ram_we_c),
        .waddr (ram_waddr_c),
        .wdata (ram_wdata_c),
        .re    (ram_re_c),
        .raddr (ram_raddr_c),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        base_d       = base_q;
        rd_k_d       = rd_k_q;
        clr_cnt_d    = clr_cnt_q;
        tap_valid_d  = tap_valid_q;
        tap_data_d   = tap_data_q;
        coef_addr_d  = coef_addr_q;
        tap_last_d   = tap_last_q;
        overrun_d    = overrun_q;
`ifdef TAP_SEQ_SAMPLE_QUEUE_EN
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
`endif
        ram_we_c     = 1'b0;
        ram_waddr_c  = wr_ptr_q;
        ram_wdata_c  = '0;
        ram_re_c     = 1'b0;
        ram_raddr_c  = base_q - rd_k_q;
        start_c      = 1'b0;
        start_data_c = '0;
        coef_next_c  = tap_valid_q ? coef_addr_q + ADDR_W'(1) : '0;

        case (state_q)
            CLEAR: begin
                ram_we_c    = 1'b1;
                ram_waddr_c = clr_cnt_q;
                clr_cnt_d   = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == '1) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
`ifdef TAP_SEQ_SAMPLE_QUEUE_EN
                // A queued sample goes first; a coincident new strobe takes its place in the queue
                if (pend_valid_q) begin
                    start_c      = 1'b1;
                    start_data_c = pend_data_q;
                    pend_valid_d = sample_valid;
                    pend_data_d  = sample_in;
                end else if (sample_valid) begin
                    start_c      = 1'b1;
                    start_data_c = sample_in;
                end
`else
                if (sample_valid) begin
                    start_c      = 1'b1;
                    start_data_c = sample_in;
                end
`endif
            end
            LOAD: begin
                ram_re_c    = 1'b1;
                ram_raddr_c = base_q;
                rd_k_d      = ADDR_W'(1);
                state_d     = RUN;
            end
            RUN: begin
                if (tap_valid_q && tap_ready && tap_last_q) begin
                    tap_valid_d = 1'b0;
                    tap_last_d  = 1'b0;
                    wr_ptr_d    = base_q + ADDR_W'(1);
                    state_d     = IDLE;
                end else if (!tap_valid_q || tap_ready) begin
                    // Advance the output from the prefetched word and fetch the following tap
                    tap_valid_d = 1'b1;
                    tap_data_d  = ram_rdata;
                    coef_addr_d = coef_next_c;
                    tap_last_d  = (coef_next_c == '1);
                    ram_re_c    = 1'b1;
                    rd_k_d      = rd_k_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase

        if (start_c) begin
            ram_we_c    = 1'b1;
            ram_waddr_c = wr_ptr_q;
            ram_wdata_c = start_data_c;
            base_d      = wr_ptr_q;
            state_d     = LOAD;
        end

        if (sample_valid && (state_q != IDLE)) begin
`ifdef TAP_SEQ_SAMPLE_QUEUE_EN
            if (!pend_valid_q) begin
                pend_valid_d = 1'b1;
                pend_data_d  = sample_in;
            end else begin
                overrun_d = 1'b1;
            end
`else
            overrun_d = 1'b1;
`endif
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR;
            wr_ptr_q     <= '0;
            base_q       <= '0;
            rd_k_q       <= '0;
            clr_cnt_q    <= '0;
            tap_valid_q  <= 1'b0;
            tap_data_q   <= '0;
            coef_addr_q  <= '0;
            tap_last_q   <= 1'b0;
            busy_q       <= 1'b1;
            overrun_q    <= 1'b0;
`ifdef TAP_SEQ_SAMPLE_QUEUE_EN
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
`endif
        end else if (clk_enable) begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            base_q       <= base_d;
            rd_k_q       <= rd_k_d;
            clr_cnt_q    <= clr_cnt_d;
            tap_valid_q  <= tap_valid_d;
            tap_data_q   <= tap_data_d;
            coef_addr_q  <= coef_addr_d;
            tap_last_q   <= tap_last_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
`ifdef TAP_SEQ_SAMPLE_QUEUE_EN
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
`endif
        end
    end

    assign tap_valid = tap_valid_q;
    assign tap_data  = tap_data_q;
    assign coef_addr = coef_addr_q;
    assign tap_last  = tap_last_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_tap_read_sequencer.sv
// Scoreboard bench for tap_read_sequencer; honours TAP_SEQ_SAMPLE_QUEUE_EN when defined.
module tb_tap_read_sequencer;

    localparam int unsigned ADDR_W   = 6;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NUM_TAPS = 64;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] k;
        logic              l;
    } beat_t;

    logic              clk;
    logic              rst;
    logic              clk_enable;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_in;
    logic              tap_valid;
    logic              tap_ready;
    logic [DATA_W-1:0] tap_data;
    logic [ADDR_W-1:0] coef_addr;
    logic              tap_last;
    logic              busy;
    logic              overrun;

    int vectors;
    int miscompares;

    beat_t             exp_q[$];
    logic [DATA_W-1:0] hist [NUM_TAPS];
    int                wptr;

    tap_read_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .clk_enable   (clk_enable),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .tap_valid    (tap_valid),
        .tap_ready    (tap_ready),
        .tap_data     (tap_data),
        .coef_addr    (coef_addr),
        .tap_last     (tap_last),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(NUM_TAPS); i++) hist[i] = '0;
        wptr = 0;
        exp_q.delete();
    endtask

    // Reference delay line: a frame is newest-to-oldest history after writing the sample
    task automatic model_accept(input logic [DATA_W-1:0] s);
        beat_t b;
        hist[wptr] = s;
        for (int k = 0; k < int'(NUM_TAPS); k++) begin
            b.d = hist[(wptr - k + int'(NUM_TAPS)) % int'(NUM_TAPS)];
            b.k = ADDR_W'(k);
            b.l = (k == int'(NUM_TAPS) - 1);
            exp_q.push_back(b);
        end
        wptr = (wptr + 1) % int'(NUM_TAPS);
    endtask

    // Single-cycle strobe; returns just after the edge that samples it
    task automatic send(input logic [DATA_W-1:0] s, input bit accept);
        if (accept) model_accept(s);
        step();
        sample_valid = 1'b1;
        sample_in    = s;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic monitor_loop();
        bit                hold_pend;
        logic [DATA_W-1:0] hold_d;
        logic [ADDR_W-1:0] hold_k;
        logic              hold_l;
        beat_t             e;
        hold_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && clk_enable) begin
                if (hold_pend) begin
                    vectors++;
                    if (tap_valid !== 1'b1 || tap_data !== hold_d || coef_addr !== hold_k || tap_last !== hold_l) begin
                        miscompares++;
                        $display("FAIL stall_hold: got v=%b d=%h k=%0d l=%b, want v=1 d=%h k=%0d l=%b",
                                 tap_valid, tap_data, coef_addr, tap_last, hold_d, hold_k, hold_l);
                    end
                end
                if (tap_valid === 1'b1 && tap_ready === 1'b1) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL beat_unexpected: got d=%h k=%0d l=%b, want no beat", tap_data, coef_addr, tap_last);
                    end else begin
                        e = exp_q.pop_front();
                        if (tap_data !== e.d || coef_addr !== e.k || tap_last !== e.l) begin
                            miscompares++;
                            $display("FAIL beat: got d=%h k=%0d l=%b, want d=%h k=%0d l=%b",
                                     tap_data, coef_addr, tap_last, e.d, e.k, e.l);
                        end
                    end
                end
                hold_pend = (tap_valid === 1'b1 && tap_ready !== 1'b1);
                hold_d    = tap_data;
                hold_k    = coef_addr;
                hold_l    = tap_last;
            end else begin
                hold_pend = 1'b0;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && busy === 1'b0) done = 1'b1;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s_drain: got %0d beats outstanding busy=%b, want 0 outstanding busy=0", name, exp_q.size(), busy);
            exp_q.delete();
        end
    endtask

    task automatic wait_beat(input int k);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (tap_valid === 1'b1 && coef_addr === ADDR_W'(k)) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL wait_beat: got no beat k=%0d, want beat k=%0d", k, k);
        end
    endtask

    task automatic check_clear_window(input string name);
        int  busy_cnt;
        bit  valid_seen;
        busy_cnt   = 0;
        valid_seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (tap_valid !== 1'b0) valid_seen = 1'b1;
        end
        vectors++;
        if (busy_cnt != 64) begin
            miscompares++;
            $display("FAIL %s_busy_cycles: got %0d, want 64", name, busy_cnt);
        end
        vectors++;
        if (valid_seen) begin
            miscompares++;
            $display("FAIL %s_no_valid: got tap_valid high, want low", name);
        end
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_overrun: got %b, want 0", name, overrun);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        vectors++;
        if (tap_valid !== 1'b0 || tap_last !== 1'b0 || tap_data !== '0 || coef_addr !== '0 ||
            overrun !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_values: got v=%b l=%b d=%h k=%0d ovr=%b busy=%b, want v=0 l=0 d=0 k=0 ovr=0 busy=1",
                     tap_valid, tap_last, tap_data, coef_addr, overrun, busy);
        end
        step();
        rst = 1'b0;
        model_clear();
        check_clear_window("reset");
    endtask

    task automatic test_enable_freeze();
        step();
        clk_enable   = 1'b0;
        sample_valid = 1'b1;
        sample_in    = 16'h7777;
        step();
        step();
        sample_valid = 1'b0;
        step();
        clk_enable = 1'b1;
        repeat (4) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || overrun !== 1'b0 || tap_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL enable_freeze: got busy=%b ovr=%b v=%b, want busy=0 ovr=0 v=0", busy, overrun, tap_valid);
        end
    endtask

    task automatic test_single();
        logic [2:0] seen;
        tap_ready = 1'b1;
        send(16'h1234, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen[i] = tap_valid;
        end
        vectors++;
        if (seen !== 3'b100) begin
            miscompares++;
            $display("FAIL first_latency: got valid seq=%b, want 100", seen);
        end
        wait_drain("single");
        vectors++;
        if (busy !== 1'b0 || tap_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_end: got busy=%b v=%b, want busy=0 v=0", busy, tap_valid);
        end
    endtask

    task automatic test_wrap();
        for (int i = 1; i <= 66; i++) begin
            send(DATA_W'(i), 1'b1);
            wait_drain("wrap");
        end
    endtask

    task automatic test_stall();
        logic pat [4];
        int   n;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        send(16'hBEEF, 1'b1);
        n = 0;
        while ((exp_q.size() != 0 || busy === 1'b1) && n < 400) begin
            tap_ready = pat[n % 4];
            step();
            n++;
        end
        tap_ready = 1'b1;
        wait_drain("stall");
    endtask

    task automatic test_midframe();
        send(16'h0A0A, 1'b1);
        wait_beat(10);
        step();
        sample_valid = 1'b1;
        sample_in    = 16'h5555;
`ifdef TAP_SEQ_SAMPLE_QUEUE_EN
        model_accept(16'h5555);
`endif
        step();
        sample_valid = 1'b0;
        @(negedge clk);
        vectors++;
`ifdef TAP_SEQ_SAMPLE_QUEUE_EN
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL queued_no_overrun: got %b, want 0", overrun);
        end
        wait_beat(20);
        step();
        sample_valid = 1'b1;
        sample_in    = 16'h6666;
        step();
        sample_valid = 1'b0;
        @(negedge clk);
        vectors++;
`endif
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL midframe_overrun: got %b, want 1", overrun);
        end
        wait_drain("midframe");
        repeat (5) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL midframe_quiet: got busy=%b, want busy=0", busy);
        end
    endtask

    task automatic test_rst_midframe();
        send(16'h4321, 1'b1);
        wait_beat(30);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_clear();
        check_clear_window("rst_mid");
        send(16'h0BAD, 1'b1);
        wait_drain("post_rst");
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        clk_enable   = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        tap_ready    = 1'b1;
        wptr         = 0;
        fork
            monitor_loop();
        join_none
        test_reset();
        test_enable_freeze();
        test_single();
        test_wrap();
        test_stall();
        test_midframe();
        test_rst_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
